// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the four-way round-robin mux arbiter.
package mux4_arb_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Binary mux select to one-hot grant vector.
  function automatic logic [NREQ-1:0] onehot4(input logic [SEL_W-1:0] sel);
    logic [NREQ-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
// master: requester/resource side, slave: arbiter side.
interface mux4_rr_arbiter_if;
  import mux4_arb_pkg::*;

  logic [NREQ-1:0]  req;
  logic             done;
  logic [NREQ-1:0]  grant;
  logic [SEL_W-1:0] sel;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req, done,
    input  grant, sel, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, sel, gnt_valid, timeout
  );
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: scans req from ptr+1 upward with
// wrap-around, so the last owner (ptr) is considered last.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NREQ-1:0]  i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_any,
  output logic [SEL_W-1:0] o_winner
);

  logic [SEL_W-1:0] w_idx;

  // First set bit after the pointer wins; offset NREQ wraps back to ptr.
  always_comb begin
    o_any    = 1'b0;
    o_winner = i_ptr;
    w_idx    = i_ptr;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_idx = i_ptr + SEL_W'(k);
      if (!o_any && i_req[w_idx]) begin
        o_any    = 1'b1;
        o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 32-bit mux.
// A grant is held until done, the owner drops its request, or (with
// ARB_TIMEOUT_EN defined) the hold counter expires.
// Optional feature macro: ARB_TIMEOUT_EN.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  mux4_rr_arbiter_if.slave bus
);

  localparam bit P_CFG_OK = (TIMEOUT_CYCLES >= 2) && (TIMEOUT_CYCLES <= 256) &&
                            ((64'd1 << CNT_W) >= 64'(TIMEOUT_CYCLES));

  if (!P_CFG_OK) begin : g_bad_cfg
    $error("mux4_rr_arbiter: illegal TIMEOUT_CYCLES/CNT_W combination");
  end

  state_t           r_state;
  logic [NREQ-1:0]  r_grant;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_ptr;
  logic             r_gnt_valid;
  logic             r_timeout;

  logic             w_any;
  logic [SEL_W-1:0] w_winner;
  logic             w_owner_req;
  logic             w_to;
  logic             w_release;
  logic             w_forced;

  // The pointer always equals the current owner while in OWN, so one picker
  // serves both the IDLE and the release paths.
  rr_pick4 u_pick (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  assign w_owner_req = bus.req[r_sel];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  // Hold counter: cleared on each new grant, counts every cycle of ownership.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == IDLE || w_release) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_to = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_to = 1'b0;
`endif

  assign w_release = bus.done | ~w_owner_req | w_to;
  // Only a release caused purely by the counter is reported as a timeout.
  assign w_forced  = w_to & ~bus.done & w_owner_req;

  // Grant FSM with registered outputs; sel parks at the last owner in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_sel       <= '0;
      r_ptr       <= SEL_W'(NREQ - 1);
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state     <= OWN;
            r_grant     <= onehot4(w_winner);
            r_sel       <= w_winner;
            r_ptr       <= w_winner;
            r_gnt_valid <= 1'b1;
          end
        end
        OWN: begin
          if (w_release) begin
            r_timeout <= w_forced;
            if (w_any) begin
              r_grant <= onehot4(w_winner);
              r_sel   <= w_winner;
              r_ptr   <= w_winner;
            end else begin
              r_state     <= IDLE;
              r_grant     <= '0;
              r_gnt_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_grant     <= '0;
          r_gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.sel       = r_sel;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.timeout   = r_timeout;

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter sharing one 32-bit datapath between four requesters.
- Drives the 2-bit select of the existing 4:1 mux: a = requester 0, b = 1, c = 2, d = 3.
- Grants one requester at a time and holds the grant until that requester's transaction completes.
- Sits between the requesters (fetch, load/store, debug, spare) and the shared mux/resource.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles a grant may be held; used only with ARB_TIMEOUT_EN; legal range 2..256.
- CNT_W, 8, width of the hold counter; must satisfy 2**CNT_W >= TIMEOUT_CYCLES.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  4  request vector; bit i = requester i.
- done  input  1  one-cycle pulse from the resource: the current owner's transaction is complete.
- grant  output  4  one-hot grant, registered; all zero when idle.
- sel  output  2  mux select, registered; binary index of the current owner.
- gnt_valid  output  1  high while any grant is active (equals OR of grant).
- timeout  output  1  one-cycle pulse on a forced release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst high at a clock edge):
  - state = IDLE; grant = 0; sel = 2'b00; gnt_valid = 0; timeout = 0.
  - last-owner pointer ptr = 3, so requester 0 has top priority after reset.
  - Reset mid-grant drops the grant on that same edge.
- States: IDLE and OWN.
- Winner selection (combinational):
  - Scan req starting at (ptr+1) mod 4, then upward with wrap-around; the first set bit wins.
  - The previous owner is scanned last, so it re-wins only if no other requester is asserting.
- IDLE:
  - If req != 0, then on the next edge: state = OWN; grant = onehot(winner); sel = winner; ptr = winner.
  - Latency from req asserted to grant visible is exactly 1 cycle.
  - done is ignored in IDLE.
- OWN, release conditions (evaluated each cycle):
  - (a) done = 1;
  - (b) the owner's req bit = 0;
  - (c) the timeout condition is met (ARB_TIMEOUT_EN only).
- OWN, on release:
  - If any req bit other than the owner's is set, or the owner's own bit is still set, compute a new winner from ptr = owner and grant it on the next edge (back-to-back, no bubble).
  - Otherwise go to IDLE with grant = 0.
- OWN, no release: grant, sel and ptr hold. Changes on non-owner req bits are ignored.
- sel while IDLE: parks at the last owner's index, so the mux output stays stable. Only reset returns sel to 0.
- Simultaneous done and owner req drop: a single release; behaviour is identical to a release on done alone.
- grant is always one-hot or zero. grant[sel] = 1 whenever gnt_valid = 1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A CNT_W-bit hold counter clears on every new grant and increments each cycle in OWN.
  - When the counter reaches TIMEOUT_CYCLES-1 without a release, the arbiter force-releases on that cycle.
  - timeout pulses for one cycle, aligned with the edge where grant changes.
  - The next winner is then chosen as for a normal release.
- Not defined: no counter is synthesised, timeout is tied to 0, and a grant may be held indefinitely.

Decomposition:
- Shared package mux4_arb_pkg:
  - state enum {IDLE, OWN};
  - constant NREQ = 4;
  - constant SEL_W = 2;
  - function onehot4(sel) returning a 4-bit one-hot vector.
- Sub-module rr_pick4 (combinational):
  - inputs: req[3:0], ptr[1:0];
  - outputs: any, winner[1:0];
  - instantiated once, used for both the IDLE and the release paths.

Test Plan:
- Reset: assert rst for 2 cycles with req = 4'b1111 -> grant = 0000, sel = 00, gnt_valid = 0, timeout = 0 throughout.
- Single requester: req = 0001 -> one cycle later grant = 0001, sel = 00. Pulse done with req dropped -> next cycle grant = 0000; sel stays 00.
- Fairness: req = 1111 held, done pulsed each cycle of ownership -> grant sequence 0001, 0010, 0100, 1000, 0001 with sel 00, 01, 10, 11, 00, back-to-back with no idle cycle.
- Owner drop and wrap:
  - req = 0100 granted (sel = 10); then req = 0000 -> grant = 0000 next cycle.
  - Then req = 1001 -> grant = 1000 (scan from 3).
  - After done -> grant = 0001.
- Mid-grant reset: grant = 0010 active, rst pulsed -> grant = 0000 and sel = 00 on that edge. After release with req = 0011 -> grant = 0001.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 4): req = 0011, no done -> grant = 0001 for exactly 4 cycles, then timeout pulses and grant = 0010. Without the macro, grant stays 0001 for 50+ cycles and timeout stays 0.
